snes_pad_poller: RTL and testbench
==================================

Name: snes_pad_poller

Overview:
Console-side driver for the SNES-style controller shift-register protocol. It generates the shared latch and serial-clock strobes on the GPIO output pins and shifts in the serial button data returned by each pad on the GPIO input pins. It presents a registered, active-high button word per pad plus a one-cycle update strobe, which mmio exposes to the processor as a memory-mapped read. One instance serves both player pads, which share the latch and clock lines.

Parameters:
CLK_DIV, 300, clock cycles per half bit period (6 us at 50 MHz); minimum 4
POLL_PERIOD, 833333, clock cycles between automatic polls (60 Hz at 50 MHz); must exceed 34*CLK_DIV
NUM_PADS, 2, number of pads sharing latch/clock
NUM_BITS, 16, bits shifted per pad per frame

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
data_in  input  NUM_PADS  raw serial data from pads (from gpio); active-low, pressed = 0
poll_req  input  1  one-cycle request for an immediate poll
latch_out  output  1  pad latch strobe (to gpioOutput)
pclk_out  output  1  pad serial clock (to gpioOutput); idles high
buttons  output  NUM_PADS*NUM_BITS  last complete frame; bit p*16+i = pad p bit i, 1 = pressed
pad_present  output  NUM_PADS  1 = pad p passed the presence check on the last frame
valid  output  1  one-cycle pulse when buttons/pad_present update
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (reset==0 at an edge): FSM to IDLE; latch_out=0, pclk_out=1, buttons=0, pad_present=0, valid=0, busy=0; poll counter, bit counter, and shift registers cleared. A reset during a frame aborts it; the partial data is discarded.
- data_in passes through a 2-flop synchronizer per pad (sub-module). All sampling uses the synchronized value.
- Poll timer: a free-running counter counts 0..POLL_PERIOD-1 and wraps. When it wraps to 0, or when poll_req==1, it raises a start condition.
  - A start condition in IDLE begins a frame.
  - A start condition outside IDLE is dropped (no queueing).
  - A simultaneous wrap and poll_req counts as one start.
- States:
  - IDLE: latch_out=0, pclk_out=1. A start condition moves to LATCH on the next edge.
  - LATCH: latch_out=1, pclk_out=1 for 2*CLK_DIV cycles, then CLK_LOW with bit index 0.
  - CLK_LOW: latch_out=0, pclk_out=0 for CLK_DIV cycles. On the last cycle, the inverted synchronized bit of each pad is shifted into position bit index. Then CLK_HIGH.
  - CLK_HIGH: pclk_out=1 for CLK_DIV cycles. If bit index==NUM_BITS-1, go to DONE; otherwise increment the index and go to CLK_LOW.
  - DONE: a single cycle. buttons and pad_present load atomically from the shift registers; valid=1 for exactly this cycle. Then IDLE.
- Outputs latch_out and pclk_out are registered (glitch-free).
- Frame timing: valid is high exactly 34*CLK_DIV cycles after the first cycle latch_out is high. busy covers LATCH through DONE inclusive.
- Presence check:
  - pad_present[p] = 1 iff pad p's inverted bits 12..15 are all 0 (a real pad drives these high).
  - When a pad fails the check, its 16 button bits load as 0, not the captured value.
- buttons holds its value between frames; it never shows partial data.

Decomposition:
- Shared package snes_pad_pkg:
  - state enum {IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE}
  - button index constants B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11
  - PRESENT_MSB=15, PRESENT_LSB=12
- One sub-module: pad_sync, a parameterized-width 2-flop synchronizer, instantiated once with width NUM_PADS.

Test Plan:
All scenarios use CLK_DIV=4, POLL_PERIOD=400, and a behavioural pad model that shifts on the pclk_out rising edge and reloads on latch.
1. After reset release, hold for 399 cycles -> latch_out rises on the wrap; high 8 cycles; then 16 pclk_out low/high pulses of 4 cycles each; valid pulses 136 cycles after the latch rise.
2. Pad0 presses B and START (model word 16'hFFF6), pad1 presses A and R (16'hF6FF) -> buttons[15:0]=16'h0009, buttons[31:16]=16'h0900, pad_present=2'b11.
3. Pad1 data_in tied 0 (unplugged, pull-down) -> pad_present[1]=0 and buttons[31:16]=0; pad0 is unaffected.
4. poll_req pulses in IDLE, then again mid-frame -> one frame starts 1 cycle after the first pulse; the second pulse is ignored (exactly one valid pulse, busy high 137 cycles).
5. reset driven low during bit 7 of a frame -> next edge: latch_out=0, pclk_out=1, buttons=0, busy=0; no valid pulse; the next frame after release is complete and correct.
6. Button state changes between frames -> buttons changes only in the valid cycle; it stays stable in all other cycles.

Source files
------------

// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES pad poller.
// Contents: poller FSM state encoding, button bit positions within a
// pad's 16-bit frame, and the bit range used by the pad presence check.
package snes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } state_e;

    // Bit positions of each button in the decoded (active-high) word.
    localparam int B      = 0;
    localparam int Y      = 1;
    localparam int SELECT = 2;
    localparam int START  = 3;
    localparam int UP     = 4;
    localparam int DOWN   = 5;
    localparam int LEFT   = 6;
    localparam int RIGHT  = 7;
    localparam int A      = 8;
    localparam int X      = 9;
    localparam int L      = 10;
    localparam int R      = 11;

    // A real pad always drives bits 12..15 high (decoded as 0).
    localparam int PRESENT_MSB = 15;
    localparam int PRESENT_LSB = 12;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data lines.
// Ports:
//   clk_i  - system clock
//   rst_ni - synchronous active-low reset (clears both stages)
//   d_i    - asynchronous input bus
//   q_o    - synchronized output bus (two cycles of latency)
module pad_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/snes_pad_poller.sv
// Console-side poller for SNES-style controller pads sharing one latch
// and one serial clock line. Periodically (or on request) latches the
// pads, clocks out NUM_BITS bits from each, and publishes a decoded,
// active-high button word per pad with a one-cycle valid strobe.
// Ports:
//   clock       - system clock, rising edge
//   reset       - synchronous active-low reset
//   data_in     - raw serial data per pad (active-low buttons)
//   poll_req    - one-cycle request for an immediate poll
//   latch_out   - pad latch strobe (registered)
//   pclk_out    - pad serial clock, idles high (registered)
//   buttons     - last complete frame, pad p at [p*NUM_BITS +: NUM_BITS]
//   pad_present - per-pad presence result of the last frame
//   valid       - one-cycle pulse when buttons/pad_present update
//   busy        - high from LATCH through DONE
module snes_pad_poller
    import snes_pad_pkg::*;
#(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833333,
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_PADS-1:0]          data_in,
    input  logic                         poll_req,
    output logic                         latch_out,
    output logic                         pclk_out,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS-1:0]          pad_present,
    output logic                         valid,
    output logic                         busy
);

    localparam int CNT_W = $clog2(POLL_PERIOD);
    localparam int CYC_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = $clog2(NUM_BITS);

    logic [NUM_PADS-1:0] data_sync;

    pad_sync #(.WIDTH(NUM_PADS)) u_pad_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (data_in),
        .q_o    (data_sync)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             latch_q, pclk_q, valid_q, busy_q;
    logic             wrap, start, sample, load;

    // Wrap and poll_req in the same cycle collapse into one start.
    assign wrap       = (poll_cnt_q == CNT_W'(POLL_PERIOD - 1));
    assign start      = wrap | poll_req;
    assign poll_cnt_d = wrap ? '0 : poll_cnt_q + 1'b1;
    assign load       = (state_d == DONE);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                    cyc_d   = '0;
                end
            end
            LATCH: begin
                if (cyc_q == CYC_W'(2 * CLK_DIV - 1)) begin
                    state_d = CLK_LOW;
                    cyc_d   = '0;
                    idx_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            CLK_LOW: begin
                if (cyc_q == CYC_W'(CLK_DIV - 1)) begin
                    // Sample at the end of the low phase, when the pad's
                    // output has long since settled through the synchronizer.
                    sample  = 1'b1;
                    state_d = CLK_HIGH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            CLK_HIGH: begin
                if (cyc_q == CYC_W'(CLK_DIV - 1)) begin
                    cyc_d = '0;
                    if (idx_q == IDX_W'(NUM_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = CLK_LOW;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly
    // with the state they belong to and never glitch.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            poll_cnt_q <= '0;
            cyc_q      <= '0;
            idx_q      <= '0;
            latch_q    <= 1'b0;
            pclk_q     <= 1'b1;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            cyc_q      <= cyc_d;
            idx_q      <= idx_d;
            latch_q    <= (state_d == LATCH);
            pclk_q     <= (state_d != CLK_LOW);
            valid_q    <= (state_d == DONE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign latch_out = latch_q;
    assign pclk_out  = pclk_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            logic [NUM_BITS-1:0] shift_q;
            logic [NUM_BITS-1:0] btn_q;
            logic                present_q;
            logic                present_ok;

            // Unplugged lines read low, so their high bits decode as pressed.
            assign present_ok = ~|shift_q[PRESENT_MSB:PRESENT_LSB];

            always_ff @(posedge clock) begin
                if (!reset) begin
                    shift_q   <= '0;
                    btn_q     <= '0;
                    present_q <= 1'b0;
                end else begin
                    if (sample) begin
                        shift_q[idx_q] <= ~data_sync[gi];
                    end
                    if (load) begin
                        present_q <= present_ok;
                        btn_q     <= present_ok ? shift_q : '0;
                    end
                end
            end

            assign buttons[gi*NUM_BITS +: NUM_BITS] = btn_q;
            assign pad_present[gi]                  = present_q;
        end
    endgenerate

endmodule

// File: tb/tb_snes_pad_poller.sv
module tb_snes_pad_poller;

    localparam int CLK_DIV     = 4;
    localparam int POLL_PERIOD = 400;
    localparam int NUM_PADS    = 2;
    localparam int NUM_BITS    = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  data_in;
    logic        poll_req = 1'b0;
    logic        latch_out, pclk_out, valid, busy;
    logic [31:0] buttons;
    logic [1:0]  pad_present;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural pads: reload on latch, shift on pclk rising edge.
    logic [15:0] word0 = 16'hFFFF;
    logic [15:0] word1 = 16'hFFFF;
    logic [15:0] sr0   = 16'hFFFF;
    logic [15:0] sr1   = 16'hFFFF;
    logic        unplug1 = 1'b0;

    always @(posedge latch_out) begin
        sr0 = word0;
        sr1 = word1;
    end

    always @(posedge pclk_out) begin
        if (!latch_out) begin
            sr0 = {1'b1, sr0[15:1]};
            sr1 = {1'b1, sr1[15:1]};
        end
    end

    assign data_in[0] = sr0[0];
    assign data_in[1] = unplug1 ? 1'b0 : sr1[0];

    always #5 clock = ~clock;

    snes_pad_poller #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD),
        .NUM_PADS    (NUM_PADS),
        .NUM_BITS    (NUM_BITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .poll_req    (poll_req),
        .latch_out   (latch_out),
        .pclk_out    (pclk_out),
        .buttons     (buttons),
        .pad_present (pad_present),
        .valid       (valid),
        .busy        (busy)
    );

    // Reset for three cycles; returns at the negedge where reset is released.
    task automatic do_reset();
        reset    = 1'b0;
        poll_req = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    // Waits (bounded) for a valid pulse, sampling on negedges.
    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_poll();
        @(negedge clock);
        poll_req = 1'b1;
        @(negedge clock);
        poll_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (latch_out !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b want 0", latch_out); end
        n_checks++; if (pclk_out !== 1'b1) begin n_fail++; $display("FAIL reset_pclk: got %b want 1", pclk_out); end
        n_checks++; if (buttons !== 32'h0) begin n_fail++; $display("FAIL reset_buttons: got %h want 0", buttons); end
        n_checks++; if (pad_present !== 2'b00) begin n_fail++; $display("FAIL reset_present: got %b want 00", pad_present); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_auto_poll();
        int first;
        int latch_err, pclk_err, valid_err, busy_err;
        logic exp_pclk;
        word0   = 16'hFFFB;   // SELECT
        word1   = 16'hFFEF;   // UP
        unplug1 = 1'b0;
        do_reset();
        first = -1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clock);
            if (latch_out === 1'b1) begin
                first = k;
                break;
            end
        end
        n_checks++;
        if (first != 400) begin
            n_fail++;
            $display("FAIL auto_first_latch: got cycle %0d want 400", first);
        end else begin
            latch_err = 0; pclk_err = 0; valid_err = 0; busy_err = 0;
            for (int j = 0; j < 140; j++) begin
                if (j > 0) @(negedge clock);
                if (j < 8)        exp_pclk = 1'b1;
                else if (j < 136) exp_pclk = (((j - 8) / 4) % 2 == 0) ? 1'b0 : 1'b1;
                else              exp_pclk = 1'b1;
                if (latch_out !== (j < 8))    latch_err++;
                if (pclk_out !== exp_pclk)    pclk_err++;
                if (valid !== (j == 136))     valid_err++;
                if (busy !== (j <= 136))      busy_err++;
                if (j == 136) begin
                    n_checks++; if (buttons !== 32'h0010_0004) begin n_fail++; $display("FAIL auto_buttons: got %h want 00100004", buttons); end
                    n_checks++; if (pad_present !== 2'b11) begin n_fail++; $display("FAIL auto_present: got %b want 11", pad_present); end
                end
            end
            n_checks++; if (latch_err != 0) begin n_fail++; $display("FAIL auto_latch_shape: got %0d bad cycles want 0", latch_err); end
            n_checks++; if (pclk_err != 0)  begin n_fail++; $display("FAIL auto_pclk_shape: got %0d bad cycles want 0", pclk_err); end
            n_checks++; if (valid_err != 0) begin n_fail++; $display("FAIL auto_valid_timing: got %0d bad cycles want 0", valid_err); end
            n_checks++; if (busy_err != 0)  begin n_fail++; $display("FAIL auto_busy_span: got %0d bad cycles want 0", busy_err); end
        end
        $display("test_auto_poll: first latch at cycle %0d", first);
    endtask

    task automatic test_buttons();
        bit found;
        word0   = 16'hFFF6;   // B + START
        word1   = 16'hF6FF;   // A + R
        unplug1 = 1'b0;
        do_reset();
        pulse_poll();
        wait_valid(found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL buttons_valid_timeout: got no valid want one");
        end else begin
            n_checks++; if (buttons[15:0] !== 16'h0009) begin n_fail++; $display("FAIL buttons_pad0: got %h want 0009", buttons[15:0]); end
            n_checks++; if (buttons[31:16] !== 16'h0900) begin n_fail++; $display("FAIL buttons_pad1: got %h want 0900", buttons[31:16]); end
            n_checks++; if (pad_present !== 2'b11) begin n_fail++; $display("FAIL buttons_present: got %b want 11", pad_present); end
        end
        $display("test_buttons: buttons=%h present=%b", buttons, pad_present);
    endtask

    task automatic test_unplugged();
        bit found;
        word0   = 16'hFFF6;
        word1   = 16'hF6FF;
        unplug1 = 1'b1;
        do_reset();
        pulse_poll();
        wait_valid(found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL unplug_valid_timeout: got no valid want one");
        end else begin
            n_checks++; if (pad_present !== 2'b01) begin n_fail++; $display("FAIL unplug_present: got %b want 01", pad_present); end
            n_checks++; if (buttons[31:16] !== 16'h0000) begin n_fail++; $display("FAIL unplug_pad1: got %h want 0000", buttons[31:16]); end
            n_checks++; if (buttons[15:0] !== 16'h0009) begin n_fail++; $display("FAIL unplug_pad0: got %h want 0009", buttons[15:0]); end
        end
        unplug1 = 1'b0;
        $display("test_unplugged: buttons=%h present=%b", buttons, pad_present);
    endtask

    task automatic test_poll_req();
        int busy_cnt, valid_cnt;
        logic latch_first;
        word0 = 16'hFFFF;
        word1 = 16'hFFFF;
        do_reset();
        @(negedge clock);
        poll_req = 1'b1;
        busy_cnt = 0; valid_cnt = 0; latch_first = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (i == 0) latch_first = latch_out;
            if (busy === 1'b1)  busy_cnt++;
            if (valid === 1'b1) valid_cnt++;
            poll_req = (i == 50);
        end
        poll_req = 1'b0;
        n_checks++; if (latch_first !== 1'b1) begin n_fail++; $display("FAIL poll_latch_start: got %b want 1", latch_first); end
        n_checks++; if (busy_cnt != 137) begin n_fail++; $display("FAIL poll_busy_len: got %0d want 137", busy_cnt); end
        n_checks++; if (valid_cnt != 1) begin n_fail++; $display("FAIL poll_valid_count: got %0d want 1", valid_cnt); end
        $display("test_poll_req: busy=%0d valid=%0d", busy_cnt, valid_cnt);
    endtask

    task automatic test_reset_mid();
        bit found;
        int valid_cnt;
        word0 = 16'hFFF6;
        word1 = 16'hF6FF;
        do_reset();
        pulse_poll();
        wait_valid(found);
        n_checks++; if (buttons !== 32'h0900_0009) begin n_fail++; $display("FAIL midrst_prefill: got %h want 09000009", buttons); end
        @(negedge clock);
        poll_req = 1'b1;
        @(negedge clock);            // first latch-high cycle
        poll_req = 1'b0;
        repeat (66) @(negedge clock); // inside bit 7 low phase
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (latch_out !== 1'b0) begin n_fail++; $display("FAIL midrst_latch: got %b want 0", latch_out); end
        n_checks++; if (pclk_out !== 1'b1) begin n_fail++; $display("FAIL midrst_pclk: got %b want 1", pclk_out); end
        n_checks++; if (buttons !== 32'h0) begin n_fail++; $display("FAIL midrst_buttons: got %h want 0", buttons); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(negedge clock);
        reset = 1'b1;
        valid_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (valid === 1'b1) valid_cnt++;
        end
        n_checks++; if (valid_cnt != 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d want 0", valid_cnt); end
        word0 = 16'hFFFE;  // B
        word1 = 16'hFEFF;  // A
        pulse_poll();
        wait_valid(found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL midrst_recover_timeout: got no valid want one");
        end else begin
            n_checks++; if (buttons !== 32'h0100_0001) begin n_fail++; $display("FAIL midrst_recover: got %h want 01000001", buttons); end
        end
        $display("test_reset_mid: buttons=%h", buttons);
    endtask

    task automatic test_back_to_back();
        int changes, bad_changes, valid_cnt;
        logic [31:0] prev;
        word0 = 16'hFFF6;
        word1 = 16'hF6FF;
        do_reset();
        prev = 32'h0;
        changes = 0; bad_changes = 0; valid_cnt = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clock);
            if (valid === 1'b1) valid_cnt++;
            if (buttons !== prev) begin
                changes++;
                if (valid !== 1'b1) bad_changes++;
            end
            prev = buttons;
            poll_req = (i == 10);
            if (i == 300) begin word0 = 16'hFFFE; word1 = 16'hFEFF; end
            if (i == 700) begin word0 = 16'hFFFF; word1 = 16'hFFFF; end
        end
        poll_req = 1'b0;
        n_checks++; if (valid_cnt != 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 3", valid_cnt); end
        n_checks++; if (changes != 3) begin n_fail++; $display("FAIL b2b_changes: got %0d want 3", changes); end
        n_checks++; if (bad_changes != 0) begin n_fail++; $display("FAIL b2b_unstable: got %0d want 0", bad_changes); end
        n_checks++; if (buttons !== 32'h0) begin n_fail++; $display("FAIL b2b_final: got %h want 0", buttons); end
        $display("test_back_to_back: valid=%0d changes=%0d", valid_cnt, changes);
    endtask

    initial begin
        test_reset();
        test_auto_poll();
        test_buttons();
        test_unplugged();
        test_poll_req();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
